// File: rtl/accel_spi_sequencer_pkg.sv
// Shared types, register map and SPI frame layout for the accelerometer sequencer.
// Frames are {rd, addr[6:0], data[7:0]}; reads carry a zero data byte.
package accel_spi_sequencer_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INIT_ISSUE,
        INIT_ACK,
        INIT_WAIT,
        PERIOD_WAIT,
        RD_ISSUE,
        RD_ACK,
        RD_WAIT,
        PUBLISH,
        ERROR
    } state_t;

    typedef enum logic [1:0] {
        PH_NONE,
        PH_ISSUE,
        PH_ACK,
        PH_WAIT
    } txn_phase_t;

    localparam int unsigned FRAME_W        = 16;
    localparam int unsigned FRAME_RW_BIT   = 15;
    localparam int unsigned FRAME_ADDR_MSB = 14;
    localparam int unsigned FRAME_ADDR_LSB = 8;
    localparam int unsigned FRAME_DATA_MSB = 7;
    localparam int unsigned FRAME_DATA_LSB = 0;

    typedef logic [FRAME_W-1:0] frame_t;

    localparam logic [6:0] REG_POWER_CTL   = 7'h2D;
    localparam logic [6:0] REG_DATA_FORMAT = 7'h31;
    localparam logic [6:0] REG_DATAX0      = 7'h32;  // X0,X1,Y0,Y1,Z0,Z1 at 0x32..0x37

    localparam logic [7:0] POWER_CTL_MEASURE   = 8'h08;
    localparam logic [7:0] DATA_FORMAT_FR_16G  = 8'h0B;

    localparam int unsigned INIT_LEN = 2;
    localparam int unsigned RD_LEN   = 6;

    function automatic frame_t make_frame(input logic rd, input logic [6:0] addr,
                                          input logic [7:0] data);
        frame_t f;
        f = '0;
        f[FRAME_RW_BIT] = rd;
        f[FRAME_ADDR_MSB:FRAME_ADDR_LSB] = addr;
        f[FRAME_DATA_MSB:FRAME_DATA_LSB] = data;
        return f;
    endfunction

    function automatic frame_t init_frame(input logic [0:0] idx);
        if (idx == 1'b0) return make_frame(1'b0, REG_POWER_CTL, POWER_CTL_MEASURE);
        return make_frame(1'b0, REG_DATA_FORMAT, DATA_FORMAT_FR_16G);
    endfunction

    function automatic frame_t read_frame(input logic [2:0] idx);
        return make_frame(1'b1, REG_DATAX0 + 7'(idx), 8'h00);
    endfunction

endpackage

// File: rtl/accel_spi_sequencer_if.sv
// SPI-master request/response signals between the sequencer and the SPI master core.
interface accel_spi_sequencer_if;
    import accel_spi_sequencer_pkg::*;

    logic   spi_start;
    frame_t spi_tx_data;
    frame_t spi_rx_data;
    logic   spi_busy;

    modport master (output spi_start, output spi_tx_data,
                    input  spi_rx_data, input spi_busy);
    modport slave  (input  spi_start, input spi_tx_data,
                    output spi_rx_data, output spi_busy);
endinterface

// File: rtl/accel_spi_sequencer_handshake.sv
// One SPI transaction: issue (start pulse), wait for busy to rise with timeout,
// wait for busy to fall. Shared by the init writes and the sample reads.
module spi_txn_handshake
    import accel_spi_sequencer_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    accel_spi_sequencer_if.master       bus,
    input  txn_phase_t                  phase,
    input  frame_t                      frame,
    output logic                        issued,
    output logic                        acked,
    output logic                        done,
    output logic                        timeout,
    output logic [7:0]                  rx_byte
);

    localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);

    logic [CW-1:0] ack_cnt;
    frame_t        tx_q;
    logic          rx_hi_unused;

    always_comb begin
        issued       = (phase == PH_ISSUE) && !bus.spi_busy;
        acked        = (phase == PH_ACK) && bus.spi_busy;
        timeout      = (phase == PH_ACK) && !bus.spi_busy && (ack_cnt == ACK_LAST);
        done         = (phase == PH_WAIT) && !bus.spi_busy;
        rx_byte      = bus.spi_rx_data[7:0];
        rx_hi_unused = ^bus.spi_rx_data[15:8];
    end

    // The new frame is presented combinationally in the start cycle and then held
    // in tx_q, so the bus value is stable until the next start.
    assign bus.spi_start   = issued;
    assign bus.spi_tx_data = issued ? frame : tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q    <= '0;
            ack_cnt <= '0;
        end else begin
            if (issued) tx_q <= frame;
            ack_cnt <= (phase == PH_ACK) ? ack_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: rtl/accel_spi_sequencer.sv
// Accelerometer SPI sequencer: two-write sensor init, then a periodic six-byte
// read burst published atomically as signed X/Y/Z samples.
module accel_spi_sequencer
    import accel_spi_sequencer_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV  = 100000,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    accel_spi_sequencer_if.master spi,
    output logic [15:0]           x_data,
    output logic [15:0]           y_data,
    output logic [15:0]           z_data,
    output logic                  data_valid,
    output logic                  init_done,
    output logic                  error
);

    localparam int unsigned PW = $clog2(SAMPLE_DIV + 1);
    localparam logic [PW-1:0] PER_LAST  = PW'(SAMPLE_DIV - 1);
    localparam logic [0:0]    INIT_LAST = 1'(INIT_LEN - 1);
    localparam logic [2:0]    RD_LAST   = 3'(RD_LEN - 1);

    state_t     state, nxt;
    txn_phase_t phase;
    frame_t     frame;
    logic       issued, acked, done, timeout;
    logic [7:0] rx_byte;

    logic [0:0]    init_idx;
    logic [2:0]    rd_idx;
    logic [PW-1:0] period_cnt;
    logic          period_run;
    logic          wrap;
    logic          init_step, rd_step;
    logic [7:0]    shadow [RD_LEN];

    spi_txn_handshake #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_txn (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (spi),
        .phase   (phase),
        .frame   (frame),
        .issued  (issued),
        .acked   (acked),
        .done    (done),
        .timeout (timeout),
        .rx_byte (rx_byte)
    );

    assign wrap = period_run && (period_cnt == PER_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:        if (enable) nxt = init_done ? PERIOD_WAIT : INIT_ISSUE;
            INIT_ISSUE:  if (!enable) nxt = IDLE; else if (issued) nxt = INIT_ACK;
            INIT_ACK:    if (timeout) nxt = ERROR; else if (acked) nxt = INIT_WAIT;
            INIT_WAIT:
                if (done) begin
                    if (!enable)                   nxt = IDLE;
                    else if (init_idx == INIT_LAST) nxt = PERIOD_WAIT;
                    else                           nxt = INIT_ISSUE;
                end
            // Wraps arriving in any other state are overruns and simply dropped.
            PERIOD_WAIT: if (!enable) nxt = IDLE; else if (wrap) nxt = RD_ISSUE;
            RD_ISSUE:    if (!enable) nxt = IDLE; else if (issued) nxt = RD_ACK;
            RD_ACK:      if (timeout) nxt = ERROR; else if (acked) nxt = RD_WAIT;
            RD_WAIT:
                if (done) begin
                    if (!enable)              nxt = IDLE;
                    else if (rd_idx == RD_LAST) nxt = PUBLISH;
                    else                      nxt = RD_ISSUE;
                end
            PUBLISH:     nxt = PERIOD_WAIT;
            ERROR:       nxt = ERROR;
            default:     nxt = IDLE;
        endcase
    end

    always_comb begin
        phase = PH_NONE;
        frame = read_frame(rd_idx);
        unique case (state)
            INIT_ISSUE, RD_ISSUE: if (enable) phase = PH_ISSUE;
            INIT_ACK, RD_ACK:     phase = PH_ACK;
            INIT_WAIT, RD_WAIT:   phase = PH_WAIT;
            default:              phase = PH_NONE;
        endcase
        if (state inside {INIT_ISSUE, INIT_ACK, INIT_WAIT}) frame = init_frame(init_idx);
        init_step = (state == INIT_WAIT) && done;
        rd_step   = (state == RD_WAIT) && done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_idx   <= '0;
            rd_idx     <= '0;
            period_cnt <= '0;
            period_run <= 1'b0;
            init_done  <= 1'b0;
            error      <= 1'b0;
            data_valid <= 1'b0;
            x_data     <= '0;
            y_data     <= '0;
            z_data     <= '0;
            for (int unsigned i = 0; i < RD_LEN; i++) shadow[i] <= '0;
        end else begin
            data_valid <= 1'b0;
            if (timeout) error <= 1'b1;

            if (state == IDLE)  init_idx <= '0;
            else if (init_step) init_idx <= init_idx + 1'b1;
            if (init_step && init_idx == INIT_LAST) init_done <= 1'b1;

            if (state inside {IDLE, PERIOD_WAIT}) rd_idx <= '0;
            else if (rd_step) rd_idx <= (rd_idx == RD_LAST) ? '0 : rd_idx + 1'b1;

            // Counter free-runs from the first PERIOD_WAIT entry until reset.
            if (nxt == PERIOD_WAIT) period_run <= 1'b1;
            if (period_run) period_cnt <= wrap ? '0 : period_cnt + 1'b1;

            if (rd_step) shadow[rd_idx] <= rx_byte;

            if (state == PUBLISH) begin
                x_data     <= {shadow[1], shadow[0]};
                y_data     <= {shadow[3], shadow[2]};
                z_data     <= {shadow[5], shadow[4]};
                data_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_accel_spi_sequencer.sv
// Directed bench for accel_spi_sequencer with a behavioural SPI master model.
module tb_accel_spi_sequencer;
    import accel_spi_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] x_data, y_data, z_data;
    logic        data_valid, init_done, error;

    int checks = 0;
    int failures = 0;

    accel_spi_sequencer_if spi ();

    accel_spi_sequencer #(
        .SAMPLE_DIV  (200),
        .ACK_TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .spi        (spi),
        .x_data     (x_data),
        .y_data     (y_data),
        .z_data     (z_data),
        .data_valid (data_valid),
        .init_done  (init_done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SPI master model: busy rises the cycle after start, stays high busy_len cycles.
    int          busy_len = 10;
    bit          mute = 1'b0;
    int          m_cnt;
    int          busy_falls = 0;
    int          starts = 0;
    logic [15:0] m_frame = '0;
    logic [15:0] frames [$];
    logic [7:0]  rd_data [6];

    function automatic logic [7:0] resp(input logic [15:0] f);
        logic [6:0] a;
        a = f[14:8];
        if (a >= 7'h32 && a <= 7'h37) return rd_data[a - 7'h32];
        return 8'h00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi.spi_busy    <= 1'b0;
            spi.spi_rx_data <= '0;
            m_cnt           <= 0;
        end else begin
            if (spi.spi_start) begin
                starts <= starts + 1;
                frames.push_back(spi.spi_tx_data);
            end
            if (spi.spi_busy) begin
                if (m_cnt == 1) begin
                    spi.spi_busy    <= 1'b0;
                    busy_falls      <= busy_falls + 1;
                    spi.spi_rx_data <= {m_frame[15:8], resp(m_frame)};
                end
                m_cnt <= m_cnt - 1;
            end else if (spi.spi_start && !mute) begin
                spi.spi_busy <= 1'b1;
                m_cnt        <= busy_len;
                m_frame      <= spi.spi_tx_data;
            end
        end
    end

    int   cyc = 0;
    int   dv_cyc [$];
    logic dv_prev = 1'b0;
    logic st_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_cyc.push_back(cyc);
            chk("dv_width", dv_prev, 1'b0);
        end
        if (spi.spi_start) chk("start_width", st_prev, 1'b0);
        if (spi.spi_busy && rst_n) chk("tx_stable", spi.spi_tx_data, m_frame);
        dv_prev <= data_valid;
        st_prev <= spi.spi_start;
    end

    int base, nd, st0;

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        rd_data[0] = 8'h34; rd_data[1] = 8'h12; rd_data[2] = 8'hFE;
        rd_data[3] = 8'hFF; rd_data[4] = 8'h00; rd_data[5] = 8'h01;
        repeat (3) @(negedge clk);
        chk("rst_start", spi.spi_start, 1'b0);
        chk("rst_tx", spi.spi_tx_data, 16'h0000);
        chk("rst_x", x_data, 16'h0000);
        chk("rst_dv", data_valid, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_error", error, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Init sequence
        enable = 1'b1;
        for (int i = 0; i < 300 && !init_done; i++) @(negedge clk);
        chk("init_done", init_done, 1'b1);
        chk("init_busy_falls", busy_falls, 2);
        chk("init_frame_count", frames.size(), 2);
        chk("init_frame0", frames[0], 16'h2D08);
        chk("init_frame1", frames[1], 16'h310B);

        // First burst
        for (int i = 0; i < 400 && dv_cyc.size() < 1; i++) @(negedge clk);
        chk("burst1_seen", dv_cyc.size(), 1);
        chk("burst1_frames", frames.size(), 8);
        for (int k = 0; k < 6; k++) chk("burst1_frame", frames[2 + k], 16'hB200 + 16'(k) * 16'h0100);
        chk("x1", x_data, 16'h1234);
        chk("y1", y_data, 16'hFFFE);
        chk("z1", z_data, 16'h0100);
        repeat (2) @(negedge clk);
        chk("dv_low", data_valid, 1'b0);

        // Period spacing
        for (int i = 0; i < 500 && dv_cyc.size() < 3; i++) @(negedge clk);
        chk("period_a", dv_cyc[1] - dv_cyc[0], 200);
        chk("period_b", dv_cyc[2] - dv_cyc[1], 200);
        chk("x_hold", x_data, 16'h1234);

        // Enable dropped during third read of a burst
        base = frames.size();
        nd   = dv_cyc.size();
        for (int i = 0; i < 300 && frames.size() < base + 3; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 50 && spi.spi_busy; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("drop_state", dut.state, IDLE);
        chk("drop_frames", frames.size(), base + 3);
        chk("drop_frame3", frames[base + 2], 16'hB400);
        chk("drop_no_dv", dv_cyc.size(), nd);
        chk("drop_x_hold", x_data, 16'h1234);
        chk("drop_init_kept", init_done, 1'b1);

        // Re-enable: no init frames, burst restarts at X0
        rd_data[0] = 8'h78; rd_data[1] = 8'h56; rd_data[2] = 8'h00;
        rd_data[3] = 8'h80; rd_data[4] = 8'hFF; rd_data[5] = 8'h7F;
        enable = 1'b1;
        for (int i = 0; i < 300 && frames.size() < base + 4; i++) @(negedge clk);
        chk("reen_frame", frames[base + 3], 16'hB200);
        for (int i = 0; i < 300 && dv_cyc.size() < nd + 1; i++) @(negedge clk);
        chk("reen_dv", dv_cyc.size(), nd + 1);
        chk("x2", x_data, 16'h5678);
        chk("y2", y_data, 16'h8000);
        chk("z2", z_data, 16'h7FFF);

        // Burst longer than the period: one wrap dropped, spacing doubles
        busy_len = 40;
        nd = dv_cyc.size();
        for (int i = 0; i < 1200 && dv_cyc.size() < nd + 2; i++) @(negedge clk);
        chk("overrun_seen", dv_cyc.size(), nd + 2);
        chk("overrun_spacing", dv_cyc[nd + 1] - dv_cyc[nd], 400);

        // ACK timeout: model ignores the next start
        mute = 1'b1;
        for (int i = 0; i < 500 && !spi.spi_start; i++) @(negedge clk);
        chk("to_start_seen", spi.spi_start, 1'b1);
        repeat (7) @(negedge clk);
        chk("to_error_early", error, 1'b0);
        repeat (2) @(negedge clk);
        chk("to_error", error, 1'b1);
        chk("to_state", dut.state, ERROR);
        st0 = starts;
        repeat (300) @(negedge clk);
        chk("to_no_start", starts, st0);
        chk("to_sticky", error, 1'b1);

        // Asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        chk("arst_error", error, 1'b0);
        chk("arst_init_done", init_done, 1'b0);
        chk("arst_x", x_data, 16'h0000);
        chk("arst_state", dut.state, IDLE);
        chk("arst_tx", spi.spi_tx_data, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/accel_spi_sequencer.md
ACCEL_SPI_SEQUENCER -- requirements
Module: accel_spi_sequencer

Interface
REQ-001 Parameter SAMPLE_DIV, default 100000: clk cycles between sample-burst starts (1 kHz at 100 MHz).
REQ-002 Parameter ACK_TIMEOUT, default 255: cycles allowed for spi_busy to rise after spi_start.
REQ-003 Clock and reset: clk input 1, system clock; rst_n input 1, reset, asynchronous, active-low.
REQ-004 enable  input  1  level; 1 = run init, then sample periodically.
REQ-005 spi_start  output  1  one-cycle transaction request to the SPI master.
REQ-006 spi_tx_data  output  16  frame: [15] = read(1)/write(0), [14:8] = register address, [7:0] = write data.
REQ-007 spi_rx_data  input  16  returned frame; [7:0] = read data.
REQ-008 spi_busy  input  1  SPI master transaction in progress.
REQ-009 x_data, y_data, z_data  output  16 each  signed axis samples, {high byte, low byte}.
REQ-010 data_valid  output  1  one-cycle pulse when all three axes update.
REQ-011 init_done  output  1  sensor configuration complete.
REQ-012 error  output  1  sticky ACK timeout flag.

Function
REQ-013 States SHALL be IDLE, INIT_ISSUE, INIT_ACK, INIT_WAIT, PERIOD_WAIT, RD_ISSUE, RD_ACK, RD_WAIT, PUBLISH and ERROR.
REQ-014 IDLE -> INIT_ISSUE when enable=1 and init_done=0; IDLE -> PERIOD_WAIT when enable=1 and init_done=1.
REQ-015 Init table: write 0x2D <= 0x08 (measure), then write 0x31 <= 0x0B (full resolution, +/-16 g), in that order.
REQ-016 Each x_ISSUE state drives spi_tx_data and pulses spi_start for exactly 1 cycle, only if spi_busy=0; otherwise it holds.
REQ-017 spi_tx_data SHALL remain stable from the spi_start cycle until spi_busy falls.
REQ-018 x_ACK waits for spi_busy=1, then moves to x_WAIT; if ACK_TIMEOUT cycles elapse, the block sets error=1 and enters ERROR.
REQ-019 x_WAIT waits for spi_busy=0, then advances the table index: to the next ISSUE, or from INIT to PERIOD_WAIT with init_done=1.
REQ-020 The period counter SHALL count 0..SAMPLE_DIV-1 free-running from the first entry to PERIOD_WAIT; the wrap starts a burst (RD_ISSUE).
REQ-021 A burst SHALL be six reads of addresses 0x32..0x37 (X0, X1, Y0, Y1, Z0, Z1), each tx = {1'b1, addr, 8'h00}.
REQ-022 spi_rx_data[7:0] SHALL be captured into a shadow byte on the RD_WAIT cycle when spi_busy falls.
REQ-023 PUBLISH SHALL copy the shadows to x/y/z_data simultaneously, pulse data_valid for 1 cycle, and return to PERIOD_WAIT.
REQ-024 A period wrap during an active burst SHALL be counted as an overrun and dropped; no queueing, and the counter keeps running.
REQ-025 enable falling mid-transaction: the current SPI transaction completes; the block then goes to IDLE without publishing; init_done is kept.
REQ-026 ERROR SHALL hold until reset; spi_start=0 in ERROR.
REQ-027 x/y/z_data SHALL change only in PUBLISH.

Reset
REQ-028 Reset SHALL set state=IDLE, spi_start=0, spi_tx_data=0, x/y/z_data=0, shadows=0, data_valid=0, init_done=0, error=0, and all counters=0.
REQ-029 Reset asserted mid-transaction SHALL take effect immediately; the SPI master is reset by the same rst_n.

Structure
REQ-030 A shared package SHALL hold the state enum, the register addresses (0x2D, 0x31, 0x32..0x37), the init values and the frame field positions.
REQ-031 One sub-module, spi_txn_handshake, SHALL implement the issue/ack/wait/timeout sequence, reused for init and read.

Verification
REQ-032 Reset, enable=1, SPI model with 10-cycle busy -> frames 0x2D08 then 0x310B; init_done=1 after the second busy fall.
REQ-033 Model returns 0x34,0x12,0xFE,0xFF,0x00,0x01 for reads -> x=0x1234, y=0xFFFE, z=0x0100; data_valid exactly 1 cycle.
REQ-034 SAMPLE_DIV=200 -> consecutive data_valid pulses exactly 200 cycles apart.
REQ-035 Model never raises busy, ACK_TIMEOUT=8 -> error=1 on the 8th wait cycle; no further spi_start.
REQ-036 enable dropped during the third read -> that read completes, no data_valid, state=IDLE; re-enable -> no init frames; the next frame is 0xB200.
REQ-037 SAMPLE_DIV=50 with a 10-cycle busy (burst > 50 cycles) -> wrap dropped; data_valid spacing is a multiple of 50.
